// File: rtl/fuzzy_pkg.sv
// Shared decode constants and state encoding for the fuzzycpu execute stage.
// R-type instructions use opcode 00000 and select the operation by funct.
// I-type instructions reuse the same 5-bit codes as their opcode.
package fuzzy_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;

  localparam logic [4:0] FN_ADD = 5'b10000;
  localparam logic [4:0] FN_SUB = 5'b11000;
  localparam logic [4:0] FN_AND = 5'b01000;
  localparam logic [4:0] FN_OR  = 5'b01100;
  localparam logic [4:0] FN_MUL = 5'b10100;
  localparam logic [4:0] FN_DIV = 5'b11100;

  localparam logic [4:0] OP_IADD = 5'b10000;
  localparam logic [4:0] OP_ISUB = 5'b11000;
  localparam logic [4:0] OP_IAND = 5'b01000;
  localparam logic [4:0] OP_IOR  = 5'b01100;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_HI   = 5'd24;
  localparam logic [4:0] REG_LO   = 5'd25;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    WB_HI,
    WB_LO
  } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, rst       clock, async active-high reset
//   start          load operands and begin WIDTH iterations
//   is_div         1 = divide, 0 = multiply (sampled with start)
//   a, b           operands (multiplier/dividend, multiplicand/divisor)
//   done           high in the cycle whose closing edge performs the last step
//   hi, lo         result of the current step; final result when done
//                  (mul: product upper/lower half, div: remainder/quotient)
module iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] m_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shift;
  logic             ge;

  // hi/lo are the step outputs rather than the registers, so the final
  // result is available on the same edge that closes the last iteration.
  // Mul: {acc_hi, acc_lo} shifts right, adding m into acc_hi on lsb=1.
  // Div: acc_hi is the partial remainder, acc_lo shifts quotient bits in.
  always_comb begin
    sum       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
    rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge        = (rem_shift >= {1'b0, m_q});
    if (div_q) begin
      hi = ge ? WIDTH'(rem_shift - {1'b0, m_q}) : rem_shift[WIDTH-1:0];
      lo = {acc_lo_q[WIDTH-2:0], ge};
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      div_q    <= is_div;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= a;
      m_q      <= b;
    end else if (busy_q) begin
      acc_hi_q <= hi;
      acc_lo_q <= lo;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the fuzzycpu execute stage: decodes one
// instruction at a time, completes add/sub/and/or in one cycle, runs mul/div
// on iter_muldiv and sequences the HI (r24) / LO (r25) writeback beats.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid / in_ready            issue handshake (ready only in IDLE)
//   in_opcode, in_funct, in_rd     decoded instruction fields
//   in_a, in_b, in_imm             operands
//   wb_valid, wb_reg, wb_data      registered register-file write port
//   illegal                        pulse after accepting an undecodable op
//   div_zero                       pulse with the HI beat of a divide by zero
module alu_sequencer
  import fuzzy_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [4:0]       in_funct,
  input  logic [4:0]       in_rd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [IMM_W-1:0] in_imm,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal,
  output logic             div_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] simm, zimm;
  logic [WIDTH-1:0] op_res;
  logic             op_single, op_mul, op_div, op_illegal;
  logic             accept, div0, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] lo_q;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign simm     = WIDTH'($signed(in_imm));
  assign zimm     = WIDTH'(in_imm);

  always_comb begin
    op_res    = '0;
    op_single = 1'b0;
    op_mul    = 1'b0;
    op_div    = 1'b0;
    if (in_opcode == OP_RTYPE) begin
      unique case (in_funct)
        FN_ADD:  begin op_single = 1'b1; op_res = in_a + in_b; end
        FN_SUB:  begin op_single = 1'b1; op_res = in_a - in_b; end
        FN_AND:  begin op_single = 1'b1; op_res = in_a & in_b; end
        FN_OR:   begin op_single = 1'b1; op_res = in_a | in_b; end
        FN_MUL:  op_mul = 1'b1;
        FN_DIV:  op_div = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (in_opcode)
        OP_IADD: begin op_single = 1'b1; op_res = in_a + simm; end
        OP_ISUB: begin op_single = 1'b1; op_res = in_a - simm; end
        OP_IAND: begin op_single = 1'b1; op_res = in_a & zimm; end
        OP_IOR:  begin op_single = 1'b1; op_res = in_a | zimm; end
        default: ;
      endcase
    end
    op_illegal = !(op_single || op_mul || op_div);
  end

  assign div0     = op_div && (in_b == '0);
  assign md_start = accept && (op_mul || (op_div && !div0));

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (op_div),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && op_mul) begin
          state_d = MUL;
        end else if (accept && op_div) begin
          state_d = div0 ? WB_HI : DIV;
        end
      end
      MUL, DIV: if (md_done) state_d = WB_HI;
      WB_HI:    state_d = WB_LO;
      WB_LO:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Writeback register. The LO beat is parked in lo_q while HI is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
      lo_q     <= '0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_single) begin
              wb_valid <= (in_rd != REG_ZERO);
              wb_reg   <= in_rd;
              wb_data  <= op_res;
            end else if (op_illegal) begin
              illegal  <= 1'b1;
            end else if (div0) begin
              wb_valid <= 1'b1;
              wb_reg   <= REG_HI;
              wb_data  <= in_a;
              div_zero <= 1'b1;
              lo_q     <= '1;
            end
          end
        end
        MUL, DIV: begin
          if (md_done) begin
            wb_valid <= 1'b1;
            wb_reg   <= REG_HI;
            wb_data  <= md_hi;
            lo_q     <= md_lo;
          end
        end
        WB_HI: begin
          wb_valid <= 1'b1;
          wb_reg   <= REG_LO;
          wb_data  <= lo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: the driver pushes the expected register
// writes / illegal pulses of each issued instruction, an independent monitor
// pops and compares whenever the DUT presents an output.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [4:0]  in_funct = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [15:0] in_imm = '0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;
  logic        div_zero;

  typedef struct {
    bit          ill;
    bit          dz;
    logic [4:0]  r;
    logic [31:0] d;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;

  alu_sequencer #(.WIDTH(32), .IMM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct  (in_funct),
    .in_rd     (in_rd),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_imm    (in_imm),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .illegal   (illegal),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit ill, input bit dz, input logic [4:0] r, input logic [31:0] d);
    ev_t e;
    e.ill = ill; e.dz = dz; e.r = r; e.d = d;
    expq.push_back(e);
  endtask

  // Reference model: architectural meaning of each instruction.
  task automatic model(input logic [4:0] op, input logic [4:0] fn, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
    logic [31:0] s, z, r;
    logic [63:0] p;
    bit          single;
    s = {{16{imm[15]}}, imm};
    z = {16'h0000, imm};
    r = '0;
    single = 1'b1;
    if (op == 5'b00000) begin
      case (fn)
        5'b10000: r = a + b;
        5'b11000: r = a - b;
        5'b01000: r = a & b;
        5'b01100: r = a | b;
        5'b10100: begin
          p = {32'h0, a} * {32'h0, b};
          push(0, 0, 5'd24, p[63:32]);
          push(0, 0, 5'd25, p[31:0]);
          single = 1'b0;
        end
        5'b11100: begin
          if (b == 0) begin
            push(0, 1, 5'd24, a);
            push(0, 0, 5'd25, 32'hFFFF_FFFF);
          end else begin
            push(0, 0, 5'd24, a % b);
            push(0, 0, 5'd25, a / b);
          end
          single = 1'b0;
        end
        default: begin push(1, 0, 5'd0, 32'h0); single = 1'b0; end
      endcase
    end else begin
      case (op)
        5'b10000: r = a + s;
        5'b11000: r = a - s;
        5'b01000: r = a & z;
        5'b01100: r = a | z;
        default: begin push(1, 0, 5'd0, 32'h0); single = 1'b0; end
      endcase
    end
    if (single && rd != 5'd0) push(0, 0, rd, r);
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] fn, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: in_ready got 0 expected 1 within 200 cycles");
    end else begin
      in_opcode = op; in_funct = fn; in_rd = rd;
      in_a = a; in_b = b; in_imm = imm;
      in_valid = 1'b1;
      model(op, fn, rd, a, b, imm);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (wb_valid || illegal || div_zero)) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got wb_valid=%b reg=%0d data=%h illegal=%b div_zero=%b expected none",
                   wb_valid, wb_reg, wb_data, illegal, div_zero);
        end else begin
          ev_t e;
          bit  ok;
          e = expq.pop_front();
          if (e.ill) ok = illegal && !wb_valid && !div_zero;
          else       ok = wb_valid && !illegal && wb_reg == e.r && wb_data == e.d && div_zero == e.dz;
          if (!ok) begin
            errors++;
            $display("FAIL scoreboard: got wb_valid=%b reg=%0d data=%h illegal=%b div_zero=%b expected ill=%b reg=%0d data=%h div_zero=%b",
                     wb_valid, wb_reg, wb_data, illegal, div_zero, e.ill, e.r, e.d, e.dz);
          end
        end
      end
    end
  end

  logic [4:0] rfn [4] = '{5'b10000, 5'b11000, 5'b01000, 5'b01100};

  initial begin
    logic [4:0]  op, fn;
    logic [31:0] a, b;
    int          k, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;

    // Back-to-back single-cycle ops
    issue(5'b00000, 5'b10000, 5'd3, 32'd7, 32'hFFFF_FFFF, 16'h0);
    check("b2b_ready", 32'(in_ready), 32'd1);
    issue(5'b01000, 5'b00000, 5'd4, 32'hF0F0_1234, 32'h0, 16'h00FF);
    issue(5'b11000, 5'b00000, 5'd5, 32'd10, 32'h0, 16'h0003);
    issue(5'b10000, 5'b00000, 5'd5, 32'd0, 32'h0, 16'hFFFF);

    // mul timing
    issue(5'b00000, 5'b10100, 5'd9, 32'hFFFF_FFFF, 32'd2, 16'h0);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      check("mul_ready", 32'(in_ready), (c <= 34) ? 32'd0 : 32'd1);
      if (c == 33) check("mul_hi_beat", {26'h0, wb_valid, wb_reg}, {26'h0, 1'b1, 5'd24});
      if (c == 34) check("mul_lo_beat", {26'h0, wb_valid, wb_reg}, {26'h0, 1'b1, 5'd25});
    end

    // div and divide by zero
    issue(5'b00000, 5'b11100, 5'd1, 32'd100, 32'd7, 16'h0);
    issue(5'b00000, 5'b11100, 5'd1, 32'd5, 32'd0, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) check("dz_hi_beat", {25'h0, div_zero, wb_valid, wb_reg}, {25'h0, 1'b1, 1'b1, 5'd24});
      if (c == 2) check("dz_lo_beat", {25'h0, div_zero, wb_valid, wb_reg}, {25'h0, 1'b0, 1'b1, 5'd25});
      if (c == 3) check("dz_ready", 32'(in_ready), 32'd1);
    end

    // Boundary cases
    issue(5'b00000, 5'b10000, 5'd0, 32'd1, 32'd2, 16'h0);
    issue(5'b00111, 5'b00000, 5'd6, 32'd1, 32'd2, 16'h0);
    issue(5'b00000, 5'b00001, 5'd6, 32'd1, 32'd2, 16'h0);

    // Reset mid-mul
    issue(5'b00000, 5'b10100, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_wb_reg", 32'(wb_reg), 32'd0);
    check("midrst_wb_data", wb_data, 32'd0);
    check("midrst_illegal", 32'(illegal), 32'd0);
    check("midrst_div_zero", 32'(div_zero), 32'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(5'b00000, 5'b10000, 5'd7, 32'd40, 32'd2, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 11);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      op = 5'b00000;
      fn = 5'b00000;
      if (k < 4) begin
        fn = rfn[k];
      end else if (k < 8) begin
        op = rfn[k-4];
      end else if (k == 8) begin
        fn = 5'b10100;
      end else if (k == 9) begin
        fn = 5'b11100;
        if ($urandom_range(0, 3) == 0) b = 32'd0;
      end else if (k == 10) begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'b00000 || op == 5'b10000 || op == 5'b11000 || op == 5'b01000 || op == 5'b01100)
          op = 5'b00111;
      end else begin
        fn = 5'($urandom_range(0, 31));
        if (fn == 5'b10000 || fn == 5'b11000 || fn == 5'b01000 || fn == 5'b01100 ||
            fn == 5'b10100 || fn == 5'b11100)
          fn = 5'b00001;
      end
      issue(op, fn, 5'($urandom_range(0, 31)), a, b, 16'($urandom));
    end

    // Drain
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
